output_schedule_arbiter: RTL and testbench

Parametrised successor of the 8-queue gated strict-priority selector in network_output_schedule. Selects one queue per packet from QUEUE_NUM queues whose gate is open and which are non-empty, then waits for the network_tx bufid ack. Queues below RR_BASE are served in strict priority, lowest index first. Queues at or above RR_BASE form a best-effort group that is optionally served round-robin. Adds an ack-timeout watchdog with an error counter, and a post-ack gap state so that queue-empty status can settle before the next selection.

---
 rtl/output_schedule_arbiter_if.sv | 36 +++
 rtl/output_schedule_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_output_schedule_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_schedule_arbiter_if.sv
// -----------------------------------------------------------------------------
// output_schedule_arbiter_if
// Schedule handshake between the output scheduler and its queue/tx neighbours.
//   iv_gate_ctrl_vector : per-queue gate open (1 = open)
//   iv_queue_empty      : per-queue empty flag (1 = empty)
//   i_pkt_bufid_ack     : network_tx has taken the bufid
//   ov_schdule_queue    : selected queue id
//   o_schdule_queue_wr  : one-cycle strobe validating ov_schdule_queue
// master = scheduler side, slave = environment (gates, queues, tx).
// -----------------------------------------------------------------------------
interface output_schedule_arbiter_if #(
   parameter int unsigned QUEUE_NUM = 8,
   parameter int unsigned QID_W     = 3
);
   logic [QUEUE_NUM-1:0] iv_gate_ctrl_vector;
   logic [QUEUE_NUM-1:0] iv_queue_empty;
   logic                 i_pkt_bufid_ack;
   logic [QID_W-1:0]     ov_schdule_queue;
   logic                 o_schdule_queue_wr;

   modport master (
      input  iv_gate_ctrl_vector,
      input  iv_queue_empty,
      input  i_pkt_bufid_ack,
      output ov_schdule_queue,
      output o_schdule_queue_wr
   );

   modport slave (
      output iv_gate_ctrl_vector,
      output iv_queue_empty,
      output i_pkt_bufid_ack,
      input  ov_schdule_queue,
      input  o_schdule_queue_wr
   );
endinterface

// File: rtl/output_schedule_arbiter.sv
// -----------------------------------------------------------------------------
// output_schedule_arbiter
// Gated queue selector: picks one eligible (gate open, non-empty) queue per
// packet, then waits for the tx bufid ack. Queues below RR_BASE are strict
// priority (lowest index wins); queues at/above RR_BASE form a best-effort
// group. An ack watchdog aborts a grant after ACK_TIMEOUT cycles and counts
// it; a one-cycle GAP_S lets queue-empty flags settle before reselecting.
//
// Optional feature macro: OSC_RR_EN
//   defined   : best-effort group served round-robin from rr_ptr
//   undefined : best-effort group served lowest index first
//
// Ports
//   i_clk          : clock
//   i_rst          : synchronous active-high reset
//   sif            : schedule handshake (master modport)
//   o_ack_timeout  : one-cycle pulse on ack timeout
//   ov_timeout_cnt : saturating timeout count
//   ov_osc_state   : current FSM state (0 IDLE, 1 ACK, 2 GAP)
// -----------------------------------------------------------------------------
module output_schedule_arbiter #(
   parameter int unsigned QUEUE_NUM   = 8,
   parameter int unsigned QID_W       = 3,
   parameter int unsigned RR_BASE     = 6,
   parameter int unsigned ACK_TIMEOUT = 1023,
   parameter int unsigned TO_W        = 10
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   output_schedule_arbiter_if.master   sif,
   output logic                        o_ack_timeout,
   output logic [15:0]                 ov_timeout_cnt,
   output logic [1:0]                  ov_osc_state
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE_S = 2'd0,
      ACK_S  = 2'd1,
      GAP_S  = 2'd2,
      ILL_S  = 2'd3
   } state_t;

   state_t               state_q, state_nxt;
   logic [QID_W-1:0]     queue_q, queue_nxt;
   logic                 wr_q, wr_nxt;
   logic                 to_q, to_nxt;
   logic [CNT_W-1:0]     timeout_cnt_q, timeout_cnt_nxt;
   logic [TO_W-1:0]      timer_q, timer_nxt;
`ifdef OSC_RR_EN
   logic [QID_W-1:0]     rr_ptr_q, rr_ptr_nxt;
`endif

   logic [QUEUE_NUM-1:0] elig;
   logic                 sp_hit;
   logic [QID_W-1:0]     sp_qid;
   logic                 be_hit;
   logic [QID_W-1:0]     be_qid;

   assign elig = sif.iv_gate_ctrl_vector & ~sif.iv_queue_empty;

   // Strict-priority group: lowest eligible index below RR_BASE.
   always_comb begin : sp_sel
      sp_hit = 1'b0;
      sp_qid = '0;
      for (int i = 0; i < int'(RR_BASE); i++) begin
         if (!sp_hit && elig[i]) begin
            sp_hit = 1'b1;
            sp_qid = QID_W'(i);
         end
      end
   end

   // Best-effort group choice.
   always_comb begin : be_sel
      be_hit = 1'b0;
      be_qid = '0;
`ifdef OSC_RR_EN
      // Two passes give a cyclic scan: first [rr_ptr, top], then wrap to the
      // lowest eligible group index (which must lie below rr_ptr).
      for (int i = int'(RR_BASE); i < int'(QUEUE_NUM); i++) begin
         if (!be_hit && elig[i] && (QID_W'(i) >= rr_ptr_q)) begin
            be_hit = 1'b1;
            be_qid = QID_W'(i);
         end
      end
      for (int i = int'(RR_BASE); i < int'(QUEUE_NUM); i++) begin
         if (!be_hit && elig[i]) begin
            be_hit = 1'b1;
            be_qid = QID_W'(i);
         end
      end
`else
      for (int i = int'(RR_BASE); i < int'(QUEUE_NUM); i++) begin
         if (!be_hit && elig[i]) begin
            be_hit = 1'b1;
            be_qid = QID_W'(i);
         end
      end
`endif
   end

   // Next-state and registered-output logic.
   always_comb begin : fsm_nxt
      state_nxt       = state_q;
      queue_nxt       = queue_q;
      wr_nxt          = 1'b0;
      to_nxt          = 1'b0;
      timeout_cnt_nxt = timeout_cnt_q;
      timer_nxt       = timer_q;
`ifdef OSC_RR_EN
      rr_ptr_nxt      = rr_ptr_q;
`endif
      case (state_q)
         IDLE_S: begin
            if (sp_hit) begin
               queue_nxt = sp_qid;
               wr_nxt    = 1'b1;
               timer_nxt = '0;
               state_nxt = ACK_S;
            end else if (be_hit) begin
               queue_nxt = be_qid;
               wr_nxt    = 1'b1;
               timer_nxt = '0;
               state_nxt = ACK_S;
`ifdef OSC_RR_EN
               if (be_qid == QID_W'(QUEUE_NUM - 1)) begin
                  rr_ptr_nxt = QID_W'(RR_BASE);
               end else begin
                  rr_ptr_nxt = be_qid + QID_W'(1);
               end
`endif
            end
         end
         ACK_S: begin
            // Ack has priority over a timeout landing in the same cycle.
            if (sif.i_pkt_bufid_ack) begin
               state_nxt = GAP_S;
            end else if (timer_q == TO_W'(ACK_TIMEOUT - 1)) begin
               to_nxt    = 1'b1;
               state_nxt = GAP_S;
               if (timeout_cnt_q != {CNT_W{1'b1}}) begin
                  timeout_cnt_nxt = timeout_cnt_q + CNT_W'(1);
               end
            end else begin
               timer_nxt = timer_q + TO_W'(1);
            end
         end
         GAP_S: begin
            state_nxt = IDLE_S;
         end
         default: begin
            state_nxt = IDLE_S;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk) begin : fsm_reg
      if (i_rst) begin
         state_q       <= IDLE_S;
         queue_q       <= '0;
         wr_q          <= 1'b0;
         to_q          <= 1'b0;
         timeout_cnt_q <= '0;
         timer_q       <= '0;
`ifdef OSC_RR_EN
         rr_ptr_q      <= QID_W'(RR_BASE);
`endif
      end else begin
         state_q       <= state_nxt;
         queue_q       <= queue_nxt;
         wr_q          <= wr_nxt;
         to_q          <= to_nxt;
         timeout_cnt_q <= timeout_cnt_nxt;
         timer_q       <= timer_nxt;
`ifdef OSC_RR_EN
         rr_ptr_q      <= rr_ptr_nxt;
`endif
      end
   end

   assign sif.ov_schdule_queue   = queue_q;
   assign sif.o_schdule_queue_wr = wr_q;
   assign o_ack_timeout          = to_q;
   assign ov_timeout_cnt         = timeout_cnt_q;
   assign ov_osc_state           = state_q;

endmodule

// File: tb/tb_output_schedule_arbiter.sv
// -----------------------------------------------------------------------------
// tb_output_schedule_arbiter
// Scenario bench for output_schedule_arbiter (QUEUE_NUM 8, RR_BASE 6,
// ACK_TIMEOUT 16). Expected grant ids are queued when stimulus is applied and
// popped when the strobe is seen.
// -----------------------------------------------------------------------------
module tb_output_schedule_arbiter;

   localparam int unsigned QN  = 8;
   localparam int unsigned QW  = 3;
   localparam int unsigned RRB = 6;
   localparam int unsigned ATO = 16;
   localparam int unsigned TW  = 5;

   logic        i_clk;
   logic        i_rst;
   logic        ack_to;
   logic [15:0] to_cnt;
   logic [1:0]  st;

   int total = 0;
   int bad   = 0;
   logic [QW-1:0] exp_q[$];
   logic [QW-1:0] exp_id;
   bit            seen;

   output_schedule_arbiter_if #(.QUEUE_NUM(QN), .QID_W(QW)) sif ();

   output_schedule_arbiter #(
      .QUEUE_NUM(QN), .QID_W(QW), .RR_BASE(RRB), .ACK_TIMEOUT(ATO), .TO_W(TW)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .sif            (sif),
      .o_ack_timeout  (ack_to),
      .ov_timeout_cnt (to_cnt),
      .ov_osc_state   (st)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #300000;
      $display("FAIL global_watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic wait_grant(input int limit, output bit got);
      got = 1'b0;
      for (int c = 0; c < limit; c++) begin
         if (!got) begin
            tick();
            if (sif.o_schdule_queue_wr === 1'b1) got = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      sif.iv_gate_ctrl_vector = '0;
      sif.iv_queue_empty      = '1;
      sif.i_pkt_bufid_ack     = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      tick();
      total++;
      if ({sif.o_schdule_queue_wr, sif.ov_schdule_queue, ack_to, to_cnt, st} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: wr=%0d q=%0d to=%0d cnt=%0d st=%0d, required all 0",
                  sif.o_schdule_queue_wr, sif.ov_schdule_queue, ack_to, to_cnt, st);
      end
      // elig = 0xFF & ~0xF5 = bits 1,3 -> queue 1 on the very next cycle
      sif.iv_gate_ctrl_vector = 8'hFF;
      sif.iv_queue_empty      = 8'hF5;
      exp_q.push_back(3'd1);
      tick();
      total++;
      if (sif.o_schdule_queue_wr !== 1'b1 || st !== 2'd1) begin
         bad++;
         $display("FAIL grant_latency: wr=%0d st=%0d, required wr=1 st=1",
                  sif.o_schdule_queue_wr, st);
      end
      exp_id = exp_q.pop_front();
      total++;
      if (sif.ov_schdule_queue !== exp_id) begin
         bad++;
         $display("FAIL reset_first_qid: got %0d, required %0d", sif.ov_schdule_queue, exp_id);
      end
      sif.i_pkt_bufid_ack = 1'b1;
      tick();
      sif.i_pkt_bufid_ack = 1'b0;
      total++;
      if (st !== 2'd2 || sif.o_schdule_queue_wr !== 1'b0) begin
         bad++;
         $display("FAIL ack_to_gap: st=%0d wr=%0d, required st=2 wr=0", st, sif.o_schdule_queue_wr);
      end
      tick();
      total++;
      if (st !== 2'd0) begin
         bad++;
         $display("FAIL gap_to_idle: st=%0d, required 0", st);
      end
      exp_q.push_back(3'd1);
      tick();
      exp_id = exp_q.pop_front();
      total++;
      if (sif.o_schdule_queue_wr !== 1'b1 || sif.ov_schdule_queue !== exp_id) begin
         bad++;
         $display("FAIL back_to_back: wr=%0d q=%0d, required wr=1 q=%0d",
                  sif.o_schdule_queue_wr, sif.ov_schdule_queue, exp_id);
      end
      sif.iv_gate_ctrl_vector = '0;
      sif.i_pkt_bufid_ack     = 1'b1;
      tick();
      sif.i_pkt_bufid_ack     = 1'b0;
      tick();
   endtask

   task automatic test_best_effort;
      sif.iv_gate_ctrl_vector = 8'hC0;
      sif.iv_queue_empty      = 8'h00;
`ifdef OSC_RR_EN
      exp_q.push_back(3'd6); exp_q.push_back(3'd7);
      exp_q.push_back(3'd6); exp_q.push_back(3'd7);
`else
      exp_q.push_back(3'd6); exp_q.push_back(3'd6);
      exp_q.push_back(3'd6); exp_q.push_back(3'd6);
`endif
      for (int g = 0; g < 4; g++) begin
         wait_grant(8, seen);
         total++;
         if (!seen) begin
            bad++;
            $display("FAIL be_grant_%0d: no strobe within 8 cycles, required a grant", g);
         end else begin
            exp_id = exp_q.pop_front();
            if (sif.ov_schdule_queue !== exp_id) begin
               bad++;
               $display("FAIL be_grant_%0d: got q=%0d, required %0d", g, sif.ov_schdule_queue, exp_id);
            end
         end
         if (g == 3) sif.iv_gate_ctrl_vector = '0;
         tick();
         sif.i_pkt_bufid_ack = 1'b1;
         tick();
         sif.i_pkt_bufid_ack = 1'b0;
      end
      exp_q.delete();
      tick();
   endtask

   task automatic test_timeout;
      int n;
      // Ack on the 16th ACK_S cycle beats the timeout.
      sif.iv_gate_ctrl_vector = 8'h01;
      wait_grant(8, seen);
      sif.iv_gate_ctrl_vector = '0;
      for (int c = 1; c < 16; c++) tick();
      total++;
      if (!seen || st !== 2'd1) begin
         bad++;
         $display("FAIL ack_last_cycle_state: seen=%0d st=%0d, required seen=1 st=1", seen, st);
      end
      sif.i_pkt_bufid_ack = 1'b1;
      tick();
      sif.i_pkt_bufid_ack = 1'b0;
      total++;
      if (st !== 2'd2 || ack_to !== 1'b0 || to_cnt !== 16'd0) begin
         bad++;
         $display("FAIL ack_wins: st=%0d to=%0d cnt=%0d, required st=2 to=0 cnt=0", st, ack_to, to_cnt);
      end
      tick();
      // No ack at all: 16 ACK_S cycles then one pulse.
      sif.iv_gate_ctrl_vector = 8'h01;
      wait_grant(8, seen);
      sif.iv_gate_ctrl_vector = '0;
      n = seen ? 1 : 0;
      for (int c = 0; c < 40; c++) begin
         if (st === 2'd1) begin
            tick();
            if (st === 2'd1) n++;
         end
      end
      total++;
      if (n != 16) begin
         bad++;
         $display("FAIL ack_s_cycles: got %0d, required 16", n);
      end
      total++;
      if (st !== 2'd2 || ack_to !== 1'b1 || to_cnt !== 16'd1) begin
         bad++;
         $display("FAIL timeout_pulse: st=%0d to=%0d cnt=%0d, required st=2 to=1 cnt=1", st, ack_to, to_cnt);
      end
      tick();
      total++;
      if (st !== 2'd0 || ack_to !== 1'b0) begin
         bad++;
         $display("FAIL timeout_single: st=%0d to=%0d, required st=0 to=0", st, ack_to);
      end
   endtask

   task automatic test_hold_grant;
      sif.iv_gate_ctrl_vector = 8'h80;
      exp_q.push_back(3'd7);
      wait_grant(8, seen);
      sif.iv_gate_ctrl_vector = 8'h84;
      exp_id = exp_q.pop_front();
      tick(); tick();
      total++;
      if (!seen || sif.ov_schdule_queue !== exp_id || sif.o_schdule_queue_wr !== 1'b0) begin
         bad++;
         $display("FAIL grant_hold: seen=%0d q=%0d wr=%0d, required seen=1 q=%0d wr=0",
                  seen, sif.ov_schdule_queue, sif.o_schdule_queue_wr, exp_id);
      end
      sif.i_pkt_bufid_ack = 1'b1;
      tick();
      sif.i_pkt_bufid_ack = 1'b0;
      exp_q.push_back(3'd2);
      wait_grant(8, seen);
      sif.iv_gate_ctrl_vector = '0;
      exp_id = exp_q.pop_front();
      total++;
      if (!seen || sif.ov_schdule_queue !== exp_id) begin
         bad++;
         $display("FAIL next_after_gap: seen=%0d q=%0d, required seen=1 q=%0d",
                  seen, sif.ov_schdule_queue, exp_id);
      end
      sif.i_pkt_bufid_ack = 1'b1;
      tick();
      sif.i_pkt_bufid_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_ack;
      sif.iv_gate_ctrl_vector = 8'h01;
      wait_grant(8, seen);
      sif.iv_gate_ctrl_vector = '0;
      for (int c = 0; c < 4; c++) tick();
      total++;
      if (!seen || st !== 2'd1) begin
         bad++;
         $display("FAIL pre_reset_state: seen=%0d st=%0d, required seen=1 st=1", seen, st);
      end
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      total++;
      if (st !== 2'd0 || sif.o_schdule_queue_wr !== 1'b0 || ack_to !== 1'b0 || to_cnt !== 16'd0) begin
         bad++;
         $display("FAIL reset_mid_ack: st=%0d wr=%0d to=%0d cnt=%0d, required all 0",
                  st, sif.o_schdule_queue_wr, ack_to, to_cnt);
      end
      tick();
      sif.i_pkt_bufid_ack = 1'b1;
      tick();
      sif.i_pkt_bufid_ack = 1'b0;
      total++;
      if (st !== 2'd0 || sif.o_schdule_queue_wr !== 1'b0) begin
         bad++;
         $display("FAIL stray_ack_idle: st=%0d wr=%0d, required st=0 wr=0", st, sif.o_schdule_queue_wr);
      end
   endtask

   task automatic test_saturate;
      force dut.timeout_cnt_q = 16'hFFFF;
      tick(); tick();
      release dut.timeout_cnt_q;
      tick();
      total++;
      if (to_cnt !== 16'hFFFF) begin
         bad++;
         $display("FAIL preload_cnt: got %0h, required ffff", to_cnt);
      end
      sif.iv_gate_ctrl_vector = 8'h01;
      wait_grant(8, seen);
      sif.iv_gate_ctrl_vector = '0;
      for (int c = 0; c < 40; c++) begin
         if (st === 2'd1) tick();
      end
      total++;
      if (!seen || ack_to !== 1'b1 || to_cnt !== 16'hFFFF) begin
         bad++;
         $display("FAIL cnt_saturate: seen=%0d to=%0d cnt=%0h, required seen=1 to=1 cnt=ffff",
                  seen, ack_to, to_cnt);
      end
      tick(); tick();
   endtask

   initial begin
      i_rst = 1'b1;
      sif.iv_gate_ctrl_vector = '0;
      sif.iv_queue_empty      = '1;
      sif.i_pkt_bufid_ack     = 1'b0;
      test_reset();
      test_best_effort();
      test_timeout();
      test_hold_grant();
      test_reset_mid_ack();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
